// File: rtl/hex_seg_pkg.sv
// hex_seg_pkg: shared definitions for the hex seven-segment driver.
//   - pio_in field bit positions
//   - blink state encoding
//   - active-low gfedcba segment table for hex digits 0..F
//   - HEX_OFF: all segments and dp dark
package hex_seg_pkg;

  localparam int unsigned PIO_DP    = 4;
  localparam int unsigned PIO_BLANK = 5;
  localparam int unsigned PIO_BLINK = 6;
  localparam int unsigned PIO_DIM   = 7;

  localparam logic [7:0] HEX_OFF = 8'hFF;

  typedef enum logic {
    BL_ON  = 1'b0,
    BL_OFF = 1'b1
  } blink_state_e;

  // Active-low, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/hex_seg_blink_timer.sv
// hex_seg_blink_timer: blink prescaler and BL_ON/BL_OFF phase FSM.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   restart     - force BL_ON with the prescaler cleared
//   enable      - blinking active; when low the FSM is held in BL_ON
//   phase_on    - phase the display should show after this clock edge
// Parameter HALF: cycles per on or off phase (>= 2).
module hex_seg_blink_timer
  import hex_seg_pkg::*;
#(
  parameter int unsigned HALF = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic phase_on
);

  localparam int unsigned         PCNT_W    = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(HALF - 1);

  blink_state_e        state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q + 1'b1;
    if (!enable || restart) begin
      state_d = BL_ON;
      pcnt_d  = '0;
    end else if (pcnt_q == PCNT_LAST) begin
      state_d = (state_q == BL_ON) ? BL_OFF : BL_ON;
      pcnt_d  = '0;
    end
  end

  // Driven from the next state so the registered output stage sees the
  // phase that becomes current on the same edge; a restart is then
  // visible together with the value that caused it.
  assign phase_on = (state_d == BL_ON);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BL_ON;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

endmodule

// File: rtl/hex_seg_driver.sv
// hex_seg_driver: drives one active-low seven-segment HEX digit from the
// 8-bit word of a hex-display PIO output port.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   pio_in[7:0]   - [3:0] digit, [4] dp, [5] blank, [6] blink, [7] dim
//   hex_n[7:0]    - active-low segments, [6:0] = g..a, [7] = dp
//   update_pulse  - one-cycle strobe when digit or dp changes
// Build option: define HEX_SEG_PWM_EN to compile in PWM dimming; without
// it pio_in[7] is ignored and the digit is never dimmed.
module hex_seg_driver
  import hex_seg_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DIM_DUTY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pio_in,
  output logic [7:0] hex_n,
  output logic       update_pulse
);

  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);

  logic [7:0] in_q, in_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] hex_n_q, hex_n_d;
  logic       update_pulse_q, update_pulse_d;

  logic       blink_rise;
  logic       phase_on;
  logic       dim_off;

  always_comb begin
    in_d           = pio_in;
    prev_d         = in_q;
    update_pulse_d = (in_q[PIO_DP:0] != prev_q[PIO_DP:0]);
    blink_rise     = in_q[PIO_BLINK] & ~prev_q[PIO_BLINK];
  end

  hex_seg_blink_timer #(
    .HALF(HALF)
  ) u_blink (
    .clk      (clk),
    .reset    (reset),
    .restart  (update_pulse_d | blink_rise),
    .enable   (in_q[PIO_BLINK]),
    .phase_on (phase_on)
  );

`ifdef HEX_SEG_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    dim_off   = in_q[PIO_DIM] && (pwm_cnt_q >= PWM_BITS'(DIM_DUTY));
  end

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

  logic unused_fields;
  assign unused_fields = ^{prev_q[PIO_DIM], prev_q[PIO_BLANK]};
`else
  localparam int unsigned unused_pwm_cfg = PWM_BITS + DIM_DUTY;

  assign dim_off = 1'b0;

  logic unused_fields;
  assign unused_fields = ^{in_q[PIO_DIM], prev_q[PIO_DIM], prev_q[PIO_BLANK]};
`endif

  always_comb begin
    hex_n_d = {~in_q[PIO_DP], seg_decode(in_q[3:0])};
    if (in_q[PIO_BLANK])  hex_n_d = HEX_OFF;
    else if (!phase_on)   hex_n_d = HEX_OFF;
    else if (dim_off)     hex_n_d = HEX_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q           <= '0;
      prev_q         <= '0;
      hex_n_q        <= HEX_OFF;
      update_pulse_q <= 1'b0;
    end else begin
      in_q           <= in_d;
      prev_q         <= prev_d;
      hex_n_q        <= hex_n_d;
      update_pulse_q <= update_pulse_d;
    end
  end

  assign hex_n        = hex_n_q;
  assign update_pulse = update_pulse_q;

endmodule
